// File: rtl/act_pkg.sv
// Shared types and F-scaled constants for the activation pipeline.
// Constant helpers take F as an argument so every instance can pick its own Q format.
package act_pkg;

    typedef enum logic [1:0] {
        MODE_HSIG  = 2'd0,
        MODE_PLAN  = 2'd1,
        MODE_HTANH = 2'd2,
        MODE_RELU  = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        SEG_LOW  = 2'd0,
        SEG_MID  = 2'd1,
        SEG_HIGH = 2'd2,
        SEG_SAT  = 2'd3
    } plan_seg_e;

    function automatic int fx_one(input int f);
        return 32'sd1 <<< f;
    endfunction

    function automatic int fx_five(input int f);
        return 32'sd5 <<< f;
    endfunction

    // 2.375 = 19/8
    function automatic int fx_2p375(input int f);
        return 32'sd19 <<< (f - 32'sd3);
    endfunction

    function automatic int fx_27_32(input int f);
        return 32'sd27 <<< (f - 32'sd5);
    endfunction

    function automatic int fx_5_8(input int f);
        return 32'sd5 <<< (f - 32'sd3);
    endfunction

    function automatic int fx_half(input int f);
        return 32'sd1 <<< (f - 32'sd1);
    endfunction

endpackage

// File: rtl/act_plan_seg.sv
// PLAN sigmoid helper: magnitude-to-region decoder (stage 1) and
// slope/offset select for an already registered region (stage 2).
module act_plan_seg
    import act_pkg::*;
#(
    parameter int W = 16,
    parameter int F = 10
) (
    input  logic [W-1:0] dec_a,
    output plan_seg_e    dec_seg,
    input  logic [W-1:0] sel_a,
    input  plan_seg_e    sel_seg,
    output logic [W:0]   sel_f
);

    localparam logic [W-1:0] BP_SAT  = W'(fx_five(F));
    localparam logic [W-1:0] BP_HIGH = W'(fx_2p375(F));
    localparam logic [W-1:0] BP_MID  = W'(fx_one(F));
    localparam logic [W:0]   ONE_U   = (W+1)'(fx_one(F));
    localparam logic [W:0]   OFF_HIGH = (W+1)'(fx_27_32(F));
    localparam logic [W:0]   OFF_MID  = (W+1)'(fx_5_8(F));
    localparam logic [W:0]   OFF_LOW  = (W+1)'(fx_half(F));

    // Region decode from the saturated magnitude
    always_comb begin
        if (dec_a >= BP_SAT) begin
            dec_seg = SEG_SAT;
        end else if (dec_a >= BP_HIGH) begin
            dec_seg = SEG_HIGH;
        end else if (dec_a >= BP_MID) begin
            dec_seg = SEG_MID;
        end else begin
            dec_seg = SEG_LOW;
        end
    end

    // Slope (as a right shift) plus offset for the chosen region
    always_comb begin
        case (sel_seg)
            SEG_SAT:  sel_f = ONE_U;
            SEG_HIGH: sel_f = {1'b0, sel_a >> 3'd5} + OFF_HIGH;
            SEG_MID:  sel_f = {1'b0, sel_a >> 3'd3} + OFF_MID;
            SEG_LOW:  sel_f = {1'b0, sel_a >> 3'd2} + OFF_LOW;
            default:  sel_f = ONE_U;
        endcase
    end

endmodule

// File: rtl/act_pipe.sv
// Three-stage fixed-point activation unit (HSIG / PLAN / HTANH / RELU) with
// valid/ready handshakes; a downstream stall freezes every stage, bubbles included.
module act_pipe
    import act_pkg::*;
#(
    parameter int W     = 16,
    parameter int F     = 10,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic signed [W:0] ONE_S     = (W+1)'(fx_one(F));
    localparam logic signed [W:0] NEG_ONE_S = -ONE_S;
    localparam logic signed [W:0] HALF_S    = (W+1)'(fx_half(F));
    localparam logic signed [W:0] ZERO_S    = '0;
    localparam logic signed [W:0] MAX_W_S   = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN_W_S   = {2'b11, {(W-1){1'b0}}};
    localparam logic [W-1:0]      MIN_X     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]      MAX_MAG   = {1'b0, {(W-1){1'b1}}};

    logic             stall_s;
    logic [W-1:0]     in_abs_s;
    plan_seg_e        plan_seg_s;
    logic [W:0]       plan_f_s;
    logic signed [W:0] x_ext_s, hsig_s, refl_s, fin_s;

    logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic [W-1:0]     s1_abs_q, s1_abs_d, s1_x_q, s1_x_d;
    act_mode_e        s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    plan_seg_e        s1_seg_q, s1_seg_d;

    logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    act_mode_e        s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic signed [W:0] s2_val_q, s2_val_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_y_q, out_y_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;

    // The most negative input has no positive twin, so its magnitude saturates.
    assign in_abs_s = !in_x[W-1] ? in_x : ((in_x == MIN_X) ? MAX_MAG : -in_x);
    assign x_ext_s  = {s1_x_q[W-1], s1_x_q};
    assign hsig_s   = (x_ext_s >>> 3'd3) + HALF_S;

    act_plan_seg #(.W(W), .F(F)) u_plan_seg (
        .dec_a   (in_abs_s),
        .dec_seg (plan_seg_s),
        .sel_a   (s1_abs_q),
        .sel_seg (s1_seg_q),
        .sel_f   (plan_f_s)
    );

    // Stage 1: capture sign, magnitude, PLAN region and sideband
    always_comb begin
        if (!stall_s) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_x[W-1];
            s1_abs_d   = in_abs_s;
            s1_x_d     = in_x;
            s1_mode_d  = act_mode_e'(in_mode);
            s1_tag_d   = in_tag;
            s1_seg_d   = plan_seg_s;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_sign_d  = s1_sign_q;
            s1_abs_d   = s1_abs_q;
            s1_x_d     = s1_x_q;
            s1_mode_d  = s1_mode_q;
            s1_tag_d   = s1_tag_q;
            s1_seg_d   = s1_seg_q;
        end
    end

    // Stage 2: PLAN segment value or the clamp/compare result of the other modes
    always_comb begin
        if (!stall_s) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_mode_d  = s1_mode_q;
            s2_tag_d   = s1_tag_q;
            case (s1_mode_q)
                MODE_HSIG: begin
                    if (hsig_s < ZERO_S)     s2_val_d = ZERO_S;
                    else if (hsig_s > ONE_S) s2_val_d = ONE_S;
                    else                     s2_val_d = hsig_s;
                end
                MODE_PLAN: s2_val_d = $signed(plan_f_s);
                MODE_HTANH: begin
                    if (x_ext_s > ONE_S)          s2_val_d = ONE_S;
                    else if (x_ext_s < NEG_ONE_S) s2_val_d = NEG_ONE_S;
                    else                          s2_val_d = x_ext_s;
                end
                MODE_RELU: begin
                    if (x_ext_s < ZERO_S) s2_val_d = ZERO_S;
                    else                  s2_val_d = x_ext_s;
                end
                default: s2_val_d = ZERO_S;
            endcase
        end else begin
            s2_valid_d = s2_valid_q;
            s2_sign_d  = s2_sign_q;
            s2_mode_d  = s2_mode_q;
            s2_tag_d   = s2_tag_q;
            s2_val_d   = s2_val_q;
        end
    end

    // Stage 3: negative-side PLAN reflection and final range clamp
    always_comb begin
        if ((s2_mode_q == MODE_PLAN) && s2_sign_q) refl_s = ONE_S - s2_val_q;
        else                                       refl_s = s2_val_q;
        if (refl_s > MAX_W_S)      fin_s = MAX_W_S;
        else if (refl_s < MIN_W_S) fin_s = MIN_W_S;
        else                       fin_s = refl_s;
        if (!stall_s) begin
            out_valid_d = s2_valid_q;
            out_y_d     = fin_s[W-1:0];
            out_tag_d   = s2_tag_q;
        end else begin
            out_valid_d = out_valid_q;
            out_y_d     = out_y_q;
            out_tag_d   = out_tag_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_abs_q    <= '0;
            s1_x_q      <= '0;
            s1_mode_q   <= MODE_HSIG;
            s1_tag_q    <= '0;
            s1_seg_q    <= SEG_LOW;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_mode_q   <= MODE_HSIG;
            s2_tag_q    <= '0;
            s2_val_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_abs_q    <= s1_abs_d;
            s1_x_q      <= s1_x_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s1_seg_q    <= s1_seg_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_mode_q   <= s2_mode_d;
            s2_tag_q    <= s2_tag_d;
            s2_val_q    <= s2_val_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_act_pipe.sv
// Bench for act_pipe: constant vector tables, backpressure and reset sequences,
// and random traffic scored against an arithmetic reference of the activation rules.
module tb_act_pipe;

    localparam int W     = 16;
    localparam int F     = 10;
    localparam int TAG_W = 4;
    localparam int ONE   = 1 << F;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_x = '0;
    logic [1:0]       in_mode = 2'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;

    act_pipe #(.W(W), .F(F), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] x; logic [1:0] mode; logic [15:0] y; } vec_t;
    typedef struct { logic [15:0] y; logic [3:0] tag; int cyc; int st; } exp_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     stall_total = 0;
    int     n_pop = 0;
    exp_t   exp_q[$];
    bit     drv_use_tbl = 1'b0;
    logic [15:0] drv_exp = '0;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference: the activation rules evaluated with plain integer arithmetic
    function automatic logic [15:0] ref_act(input int x, input int m);
        int y, a, f;
        case (m)
            0: begin
                y = (x >>> 3) + ONE / 2;
                if (y < 0) y = 0;
                if (y > ONE) y = ONE;
            end
            1: begin
                a = (x < 0) ? -x : x;
                if (a > 32767) a = 32767;
                if (a >= 5 * ONE)           f = ONE;
                else if (8 * a >= 19 * ONE) f = a / 32 + (27 * ONE) / 32;
                else if (a >= ONE)          f = a / 8 + (5 * ONE) / 8;
                else                        f = a / 4 + ONE / 2;
                y = (x >= 0) ? f : ONE - f;
            end
            2: y = (x > ONE) ? ONE : ((x < -ONE) ? -ONE : x);
            default: y = (x < 0) ? 0 : x;
        endcase
        return y[15:0];
    endfunction

    // Monitor: samples on the falling edge, scores outputs, checks handshake rules
    initial begin
        bit prev_hold = 1'b0;
        bit hold;
        logic [15:0] prev_y = '0;
        logic [3:0]  prev_tag = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                cyc++;
                hold = out_valid && !out_ready;
                if (hold) stall_total++;
                chk("in_ready", int'(in_ready), int'(!hold));
                if (prev_hold) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_y_stable", int'(out_y), int'(prev_y));
                    chk("stall_tag_stable", int'(out_tag), int'(prev_tag));
                end
                if (out_valid && out_ready) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_y", int'($signed(out_y)), int'($signed(e.y)));
                        chk("out_tag", int'(out_tag), int'(e.tag));
                        chk("latency", cyc - e.cyc - (stall_total - e.st), 3);
                    end
                end
                if (in_valid && in_ready) begin
                    e.y   = drv_use_tbl ? drv_exp : ref_act(int'($signed(in_x)), int'(in_mode));
                    e.tag = in_tag;
                    e.cyc = cyc;
                    e.st  = stall_total;
                    exp_q.push_back(e);
                end
                prev_hold = hold;
                prev_y    = out_y;
                prev_tag  = out_tag;
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [1:0] m, input logic [3:0] tag,
                        input bit use_tbl, input logic [15:0] want);
        bit acc = 1'b0;
        int guard = 0;
        in_valid = 1'b1; in_x = x; in_mode = m; in_tag = tag;
        drv_use_tbl = use_tbl; drv_exp = want;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [15:0] pick_x();
        logic [15:0] edge_v [15] = '{16'h8000, 16'h7FFF, 16'd5120, 16'hEC00, 16'd2432,
                                     16'd2431, 16'hF680, 16'd1024, 16'd1023, 16'hFC00,
                                     16'hFBFF, 16'h0000, 16'hFFFF, 16'h1000, 16'hEFFF};
        if ($urandom_range(0, 1) == 0) return 16'($urandom);
        return edge_v[$urandom_range(0, 14)];
    endfunction

    vec_t tbl [17];
    logic [15:0] inter_exp [4];

    initial begin
        bit stop = 1'b0;
        int st0, p0;
        tbl[0]  = '{16'h1001, 2'd0, 16'd1024};
        tbl[1]  = '{16'hEFFF, 2'd0, 16'd0};
        tbl[2]  = '{16'h1000, 2'd0, 16'd1024};
        tbl[3]  = '{16'hF000, 2'd0, 16'd0};
        tbl[4]  = '{16'h0FFF, 2'd0, 16'd1023};
        tbl[5]  = '{16'hF001, 2'd0, 16'd0};
        tbl[6]  = '{16'hF600, 2'd0, 16'd192};
        tbl[7]  = '{16'h0200, 2'd1, 16'd640};
        tbl[8]  = '{16'hF600, 2'd1, 16'd80};
        tbl[9]  = '{16'h1400, 2'd1, 16'd1024};
        tbl[10] = '{16'h8000, 2'd1, 16'd0};
        tbl[11] = '{16'h0000, 2'd1, 16'd512};
        tbl[12] = '{16'h0A00, 2'd2, 16'd1024};
        tbl[13] = '{16'hF600, 2'd2, 16'hFC00};
        tbl[14] = '{16'h0100, 2'd2, 16'd256};
        tbl[15] = '{16'hF600, 2'd3, 16'd0};
        tbl[16] = '{16'h7FFF, 2'd3, 16'h7FFF};
        inter_exp[0] = 16'd192; inter_exp[1] = 16'd80;
        inter_exp[2] = 16'hFC00; inter_exp[3] = 16'd0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // constant vectors, back to back
        for (int i = 0; i < 17; i++) send(tbl[i].x, tbl[i].mode, 4'(i), 1'b1, tbl[i].y);
        idle(6);

        // mode interleave on a constant input
        for (int i = 0; i < 12; i++) send(16'hF600, 2'(i % 4), 4'(i), 1'b1, inter_exp[i % 4]);
        idle(6);

        // backpressure: out_ready low during cycles 4..7 of the stream
        st0 = stall_total; p0 = n_pop;
        fork
            begin
                for (int i = 0; i < 6; i++) send(pick_x(), 2'($urandom_range(0, 3)), 4'(i), 1'b0, 16'd0);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                for (int c = 1; c < 12; c++) begin
                    @(posedge clk); #1;
                    out_ready = !(c >= 4 && c <= 7);
                end
            end
        join
        idle(8);
        chk("bp_stall_cycles", stall_total - st0, 4);
        chk("bp_outputs", n_pop - p0, 6);

        // reset with three samples in flight
        send(16'h0200, 2'd1, 4'd1, 1'b0, 16'd0);
        send(16'hF600, 2'd0, 4'd2, 1'b0, 16'd0);
        send(16'h0100, 2'd2, 4'd3, 1'b0, 16'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1; in_x = 16'h0A00; in_mode = 2'd2; in_tag = 4'd9;
        drv_use_tbl = 1'b1; drv_exp = 16'd1024;
        #1;
        chk("rst_quiet_0", int'(out_valid), 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            chk($sformatf("post_rst_valid_%0d", k), int'(out_valid), (k == 3) ? 1 : 0);
        end
        idle(4);

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(pick_x(), 2'($urandom_range(0, 3)), 4'($urandom), 1'b0, 16'd0);
                end
                in_valid = 1'b0;
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
